// File: rtl/qif_pkg.sv
// Shared types, default constants and the saturation helper for the QIF neuron core.
package qif_pkg;

  localparam int unsigned QIF_W       = 8;
  localparam int          QIF_V_TH    = 50;
  localparam int          QIF_V_RESET = -20;
  localparam int unsigned QIF_T_REF   = 3;

  typedef logic signed [QIF_W-1:0] v_t;
  typedef logic [3:0]              refr_t;

  typedef enum logic {
    ST_INTEGRATE  = 1'b0,
    ST_REFRACTORY = 1'b1
  } qif_state_e;

  // Clamp a sign-extended sum into the signed range of a w-bit word.
  function automatic logic signed [31:0] sat_w(input logic signed [31:0] x,
                                               input int unsigned w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -hi - 1;
    if (x > hi)      sat_w = hi;
    else if (x < lo) sat_w = lo;
    else             sat_w = x;
  endfunction

endpackage

// File: rtl/qif_cell.sv
// One quadratic integrate-and-fire neuron: saturating datapath, refractory FSM, registers.
// Optional leak term enabled by defining QIF_LEAK_EN.
module qif_cell
  import qif_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned SQ_SHIFT   = 4,
  parameter int          V_TH       = QIF_V_TH,
  parameter int          V_RESET    = QIF_V_RESET,
  parameter int unsigned T_REF      = QIF_T_REF,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                step_valid_i,
  input  logic signed [W-1:0] i_syn_i,
  output logic signed [W-1:0] v_mem_o,
  output logic                spike_o,
  output logic                spike_c_o
);

  localparam int unsigned SW   = 2 * W;
  localparam int unsigned SUMW = 2 * W + 2;

  localparam logic signed [W-1:0] VTH_W  = W'(V_TH);
  localparam logic signed [W-1:0] VRST_W = W'(V_RESET);
  localparam refr_t               REF_W  = refr_t'(T_REF);

  if (T_REF > 15 || LEAK_SHIFT >= W) begin : g_bad_cfg
    $error("qif_cell: T_REF must be 0..15 and LEAK_SHIFT below W");
  end

  qif_state_e          st_q, st_d;
  refr_t               refr_q, refr_d;
  logic signed [W-1:0] v_q, v_d;
  logic                spike_q, spike_d;

  logic signed [SW-1:0]   prod;
  logic signed [SW-1:0]   sq;
  logic signed [SUMW-1:0] sum;
  logic signed [W-1:0]    v_sat;

  // Full-precision quadratic update, then clamp back to W bits.
  always_comb begin
    prod = SW'(v_q) * SW'(v_q);
    sq   = prod >>> SQ_SHIFT;
`ifdef QIF_LEAK_EN
    sum  = SUMW'(v_q) + SUMW'(sq) + SUMW'(i_syn_i) - SUMW'(v_q >>> LEAK_SHIFT);
`else
    sum  = SUMW'(v_q) + SUMW'(sq) + SUMW'(i_syn_i);
`endif
    v_sat = W'(sat_w(32'(sum), W));
  end

  always_comb begin
    st_d    = st_q;
    refr_d  = refr_q;
    v_d     = v_q;
    spike_d = 1'b0;
    if (step_valid_i) begin
      case (st_q)
        ST_INTEGRATE: begin
          if (v_sat >= VTH_W) begin
            spike_d = 1'b1;
            v_d     = VRST_W;
            if (T_REF != 0) begin
              st_d   = ST_REFRACTORY;
              refr_d = REF_W;
            end
          end else begin
            v_d = v_sat;
          end
        end
        ST_REFRACTORY: begin
          v_d    = VRST_W;
          refr_d = refr_q - refr_t'(1);
          if (refr_q == refr_t'(1)) st_d = ST_INTEGRATE;
        end
        default: st_d = ST_INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      st_q    <= ST_INTEGRATE;
      refr_q  <= '0;
      v_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      refr_q  <= refr_d;
      v_q     <= v_d;
      spike_q <= spike_d;
    end
  end

  assign v_mem_o   = v_q;
  assign spike_o   = spike_q;
  assign spike_c_o = spike_d;

endmodule

// File: rtl/qif_neuron_array.sv
// Array of independent QIF neurons on a shared step strobe; packs buses, registers out_valid/spike_any.
// Optional leak term enabled by defining QIF_LEAK_EN.
module qif_neuron_array
  import qif_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned N_NEURON   = 4,
  parameter int unsigned SQ_SHIFT   = 4,
  parameter int          V_TH       = QIF_V_TH,
  parameter int          V_RESET    = QIF_V_RESET,
  parameter int unsigned T_REF      = QIF_T_REF,
  parameter int unsigned LEAK_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step_valid,
  input  logic [N_NEURON*W-1:0]   I_syn,
  output logic [N_NEURON*W-1:0]   V_mem,
  output logic [N_NEURON-1:0]     spike,
  output logic                    out_valid,
  output logic                    spike_any
);

  logic [N_NEURON-1:0] spike_c;
  logic                out_valid_q;
  logic                spike_any_q;

  for (genvar k = 0; k < N_NEURON; k++) begin : g_cell
    qif_cell #(
      .W          (W),
      .SQ_SHIFT   (SQ_SHIFT),
      .V_TH       (V_TH),
      .V_RESET    (V_RESET),
      .T_REF      (T_REF),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_cell (
      .clk          (clk),
      .rst_n        (rst_n),
      .step_valid_i (step_valid),
      .i_syn_i      (I_syn[k*W +: W]),
      .v_mem_o      (V_mem[k*W +: W]),
      .spike_o      (spike[k]),
      .spike_c_o    (spike_c[k])
    );
  end

  // Aggregate flags registered alongside the per-neuron spike registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_valid_q <= 1'b0;
      spike_any_q <= 1'b0;
    end else begin
      out_valid_q <= step_valid;
      spike_any_q <= |spike_c;
    end
  end

  assign out_valid = out_valid_q;
  assign spike_any = spike_any_q;

endmodule

// File: doc/qif_neuron_array.md
# qif_neuron_array

Parametrised array of N_NEURON quadratic integrate-and-fire neurons with signed W-bit membrane state. Each neuron has a saturating datapath, a configurable threshold and reset potential, and an absolute refractory counter. All neurons update in parallel on a shared step strobe. The block is the next-generation neuron core, sitting between the synaptic-current aggregation stage (I_syn) and the spike router (spike, V_mem taps).

## Interface
- W, 8: membrane and input width, signed two's complement.
- N_NEURON, 4: number of parallel neurons.
- SQ_SHIFT, 4: arithmetic right shift applied to V*V.
- V_TH, 50: spike threshold, signed W-bit.
- V_RESET, -20: post-spike potential, signed W-bit.
- T_REF, 3: refractory length in steps, 0..15; 0 disables refractoriness.
- LEAK_SHIFT, 3: leak shift, used only when QIF_LEAK_EN is defined.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-high reset.
- step_valid  in  1  one-cycle strobe; each high cycle is one integration step.
- I_syn  in  N_NEURON*W  packed signed currents; neuron k is at [k*W +: W].
- V_mem  out  N_NEURON*W  registered membrane potentials, packed the same way.
- spike  out  N_NEURON  registered per-neuron spike pulses.
- out_valid  out  1  registered copy of step_valid.
- spike_any  out  1  registered OR of the spike bits.

## Operation
- Reset (rst_n=1) forces the following, independent of clk:
  - V_mem = 0 for every neuron.
  - spike = 0, spike_any = 0, out_valid = 0.
  - All refractory counters = 0.
- step_valid=0: V_mem and the refractory counters hold; spike, spike_any and out_valid are 0.
- Each neuron has two states, INTEGRATE (refr==0) and REFRACTORY (refr>0).
- INTEGRATE, on step_valid:
  - sq = (V*V) >>> SQ_SHIFT, computed at 2W width. sq is always non-negative.
  - sum = V + sq + I_syn, computed at 2W+2 width with no intermediate truncation.
  - V_sat = sum clamped to [-2^(W-1), 2^(W-1)-1].
  - If V_sat >= V_TH (signed compare): spike=1, V <= V_RESET, refr <= T_REF. If T_REF=0 the neuron stays in INTEGRATE.
  - Otherwise: V <= V_sat, spike=0.
- REFRACTORY, on step_valid:
  - V held at V_RESET, I_syn ignored, spike=0, refr <= refr-1.
  - The neuron returns to INTEGRATE once refr reaches 0. The next step after that integrates normally.
- Neurons are fully independent. Several neurons may spike on the same step.
- If reset is asserted mid-step, the reset values win. No step completes during reset or on the edge where reset deasserts.

## Timing
- Latency is 1 cycle. A step_valid high at edge t produces updated V_mem, spike, spike_any and out_valid after edge t+1. V_mem is then held until the next step.
- spike and out_valid are single-cycle pulses aligned with each other.
- Back-to-back step_valid is supported at full rate. Each step uses the V_mem value registered by the previous step.
- There is no backpressure; the consumer must sample on out_valid.

## Configuration
- QIF_LEAK_EN defined: INTEGRATE computes sum = V + sq + I_syn - (V >>> LEAK_SHIFT). Saturation and threshold rules are unchanged.
- QIF_LEAK_EN undefined: there is no leak term, and LEAK_SHIFT is unused.

## Structure
- Package qif_pkg holds:
  - typedef v_t (signed [W-1:0]).
  - typedef refr_t (4-bit).
  - the saturation function sat_w.
  - default constants QIF_V_TH, QIF_V_RESET, QIF_T_REF.
- Sub-module qif_cell is one neuron: datapath, refractory counter and registers. It is instantiated N_NEURON times with a generate loop.
- The top level does bus unpack/pack and computes out_valid and spike_any.

## Test plan
All scenarios use default parameters and QIF_LEAK_EN undefined unless stated.
- Reset: assert rst_n mid-run with V_mem nonzero -> V_mem=0, spike=0 and out_valid=0 immediately, without waiting for a clock edge.
- Integration: neuron 0 from V=0 with I=10 and steps back-to-back -> V_mem 10, then 26, then spike=1 with V_mem=-20 on step 3.
- Refractory: continue with I=10 -> steps 4-6 give V=-20, spike=0; step 7 gives V=-20+25+10=15.
- Saturation: from V=0, I=-128 gives V=-128 with no spike. Then I=0 gives sum 896, clamped to 127 -> spike=1, V_mem=-20.
- Independence and hold:
  - Neurons 0 and 2 cross threshold on the same step -> spike=4'b0101, spike_any=1.
  - step_valid low for 5 cycles -> V_mem unchanged, spike=0.
- QIF_LEAK_EN defined: from V=40 with I=0 -> 40 + 100 - 5 = 135, clamped to 127 -> spike. From V=8 with I=0 -> 8 + 4 - 1 = 11.
